// File: rtl/cache_pkg.sv
// Shared types and default geometry for the direct-mapped instruction cache.
package cache_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    MEM_READ = 2'd1,
    FLUSH    = 2'd2
  } cache_state_t;

  localparam int DEF_ADDR_W      = 32;
  localparam int DEF_NUM_SETS    = 8;
  localparam int DEF_BLOCK_WORDS = 4;

  localparam int OFFSET_W = $clog2(DEF_BLOCK_WORDS);
  localparam int INDEX_W  = $clog2(DEF_NUM_SETS);
  localparam int TAG_W    = DEF_ADDR_W - 2 - OFFSET_W - INDEX_W;
  localparam int BLOCK_W  = 32 * DEF_BLOCK_WORDS;

  // addi x0, x0, 0
  localparam logic [31:0] NOP = 32'h0000_0013;

endpackage

// File: rtl/icache_line_array.sv
// Valid/tag/data storage: one block write port, global valid clear, combinational read by index.
module icache_line_array #(
  parameter int NUM_SETS    = 8,
  parameter int BLOCK_WORDS = 4,
  parameter int INDEX_BITS  = 3,
  parameter int TAG_BITS    = 25
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          clear_all,
  input  logic                          wr_en,
  input  logic [INDEX_BITS-1:0]         wr_index,
  input  logic [TAG_BITS-1:0]           wr_tag,
  input  logic [BLOCK_WORDS-1:0][31:0]  wr_data,
  input  logic [INDEX_BITS-1:0]         rd_index,
  output logic                          rd_valid,
  output logic [TAG_BITS-1:0]           rd_tag,
  output logic [BLOCK_WORDS-1:0][31:0]  rd_data
);

  logic [NUM_SETS-1:0]              valid;
  logic [TAG_BITS-1:0]              tag_mem  [NUM_SETS];
  logic [BLOCK_WORDS-1:0][31:0]     data_mem [NUM_SETS];

  // Only the valid bits carry reset; clear wins over a same-cycle write.
  always_ff @(posedge clk) begin
    if (!reset) begin
      valid <= '0;
    end else if (clear_all) begin
      valid <= '0;
    end else if (wr_en) begin
      valid[wr_index] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      tag_mem[wr_index]  <= wr_tag;
      data_mem[wr_index] <= wr_data;
    end
  end

  assign rd_valid = valid[rd_index];
  assign rd_tag   = tag_mem[rd_index];
  assign rd_data  = data_mem[rd_index];

endmodule

// File: rtl/instruction_cache.sv
// Direct-mapped read-only instruction cache: zero-latency hits, whole-block refill on miss, flush.
module instruction_cache
  import cache_pkg::*;
#(
  parameter int ADDR_W      = DEF_ADDR_W,
  parameter int NUM_SETS    = DEF_NUM_SETS,
  parameter int BLOCK_WORDS = DEF_BLOCK_WORDS
) (
  input  logic                                   clk,
  input  logic                                   reset,
  input  logic [ADDR_W-1:0]                      address,
  input  logic                                   read,
  input  logic                                   flush,
  output logic [31:0]                            instruction,
  output logic                                   busywait,
  output logic                                   mem_read,
  output logic [ADDR_W-3-$clog2(BLOCK_WORDS):0]  mem_address,
  input  logic [32*BLOCK_WORDS-1:0]              mem_readdata,
  input  logic                                   mem_busywait,
  output cache_state_t                           dbg_state
);

  localparam int OFFSET_BITS = $clog2(BLOCK_WORDS);
  localparam int INDEX_BITS  = $clog2(NUM_SETS);
  localparam int BADDR_W     = ADDR_W - 2 - OFFSET_BITS;
  localparam int TAG_BITS    = BADDR_W - INDEX_BITS;

  // Handshake: busywait high means the fetch unit must hold and retry; mem_read stays high
  // with a stable mem_address until the cycle mem_busywait is low, which completes the fill.

  cache_state_t                 state, next_state;
  logic                         flush_pending, flush_pending_next;
  logic [BADDR_W-1:0]           block_q;
  logic [31:0]                  instr_q;
  logic [OFFSET_BITS-1:0]       offset;
  logic [INDEX_BITS-1:0]        index;
  logic [TAG_BITS-1:0]          tag;
  logic                         rd_valid;
  logic [TAG_BITS-1:0]          rd_tag;
  logic [BLOCK_WORDS-1:0][31:0] rd_data;
  logic [BLOCK_WORDS-1:0][31:0] fill_data;
  logic                         hit, take_hit, latch_miss, fill, clear_all;
  logic [31:0]                  hit_word;
  logic [1:0]                   unused_addr_bits;

  assign offset           = address[OFFSET_BITS+1:2];
  assign index            = address[OFFSET_BITS+2 +: INDEX_BITS];
  assign tag              = address[ADDR_W-1 -: TAG_BITS];
  assign unused_addr_bits = address[1:0];
  assign fill_data        = mem_readdata;
  assign hit_word         = rd_data[offset];

  assign hit         = (state == IDLE) && read && rd_valid && (rd_tag == tag);
  assign take_hit    = hit && !flush;
  assign instruction = take_hit ? hit_word : instr_q;
  assign mem_address = block_q;
  assign dbg_state   = state;

  icache_line_array #(
    .NUM_SETS    (NUM_SETS),
    .BLOCK_WORDS (BLOCK_WORDS),
    .INDEX_BITS  (INDEX_BITS),
    .TAG_BITS    (TAG_BITS)
  ) u_lines (
    .clk       (clk),
    .reset     (reset),
    .clear_all (clear_all),
    .wr_en     (fill),
    .wr_index  (block_q[INDEX_BITS-1:0]),
    .wr_tag    (block_q[BADDR_W-1 -: TAG_BITS]),
    .wr_data   (fill_data),
    .rd_index  (index),
    .rd_valid  (rd_valid),
    .rd_tag    (rd_tag),
    .rd_data   (rd_data)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state         <= IDLE;
      flush_pending <= 1'b0;
      instr_q       <= '0;
      block_q       <= '0;
    end else begin
      state         <= next_state;
      flush_pending <= flush_pending_next;
      if (take_hit)   instr_q <= hit_word;
      if (latch_miss) block_q <= address[ADDR_W-1 -: BADDR_W];
    end
  end

  always_comb begin
    next_state         = state;
    flush_pending_next = flush_pending;
    busywait           = 1'b0;
    mem_read           = 1'b0;
    latch_miss         = 1'b0;
    fill               = 1'b0;
    clear_all          = 1'b0;
    case (state)
      IDLE: begin
        if (flush) begin
          busywait   = 1'b1;
          next_state = FLUSH;
        end else if (read && !hit) begin
          busywait   = 1'b1;
          latch_miss = 1'b1;
          next_state = MEM_READ;
        end
      end
      MEM_READ: begin
        mem_read = 1'b1;
        busywait = 1'b1;
        if (flush) flush_pending_next = 1'b1;
        // A flush seen during the fill must also discard the line being filled.
        if (!mem_busywait) begin
          fill       = 1'b1;
          next_state = (flush_pending || flush) ? FLUSH : IDLE;
        end
      end
      FLUSH: begin
        busywait   = 1'b1;
        clear_all  = 1'b1;
        next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
    if (next_state == FLUSH) flush_pending_next = 1'b0;
    if (!reset) begin
      busywait   = 1'b0;
      mem_read   = 1'b0;
      latch_miss = 1'b0;
      fill       = 1'b0;
      clear_all  = 1'b0;
    end
  end

endmodule

// File: doc/instruction_cache.md
Name: instruction_cache

Overview:
Direct-mapped, read-only instruction cache between instruction_fetch_unit (CPU side) and the instruction memory (memory side).
- Hits return the instruction in the same cycle with busywait low.
- Misses stall fetch via busywait while one whole block is fetched from memory.
- A flush input invalidates every line, so the OS context-switch path can discard stale code without a reset.

Parameters:
- ADDR_W, 32, byte-address width on the CPU side.
- NUM_SETS, 8, number of lines; power of two, at least 2.
- BLOCK_WORDS, 4, 32-bit words per line; power of two, at least 2.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-low reset; sampled only on the rising clk edge.
- address  in  ADDR_W  CPU fetch byte address; bits [1:0] ignored.
- read  in  1  fetch request.
- flush  in  1  invalidate all lines (single-cycle pulse or level).
- instruction  out  32  fetched word.
- busywait  out  1  stall to fetch unit.
- mem_read  out  1  block read request to instruction memory.
- mem_address  out  ADDR_W-2-log2(BLOCK_WORDS)  block address.
- mem_readdata  in  32*BLOCK_WORDS  block data; word 0 in the LSBs.
- mem_busywait  in  1  memory busy; data is valid in the cycle it is low while mem_read is high.

Behaviour:
- Address split (defaults in brackets):
  - offset = address[log2(BLOCK_WORDS)+1:2] [3:2]
  - index = next log2(NUM_SETS) bits [6:4]
  - tag = remaining upper bits [31:7], 25 bits at default.
- Per-line storage: valid bit, tag, BLOCK_WORDS data words.
- hit = read & valid[index] & (tag_store[index] == tag). Evaluated combinationally, in IDLE only.
- FSM states: IDLE, MEM_READ, FLUSH.
- IDLE:
  - read & hit: instruction = selected word, busywait = 0, zero-cycle latency.
  - read & miss: busywait = 1 in the same cycle; latch block address and index; next state MEM_READ.
  - flush (takes priority over read): busywait = 1; next state FLUSH.
  - read low: busywait = 0; instruction holds its last value.
- MEM_READ:
  - mem_read = 1 and busywait = 1; mem_address driven from the latched address, stable for the whole request.
  - On the edge where mem_busywait == 0: write mem_readdata into the line, set valid, write the tag; drop mem_read; next state IDLE.
  - The refetch in IDLE then hits. Miss penalty = memory latency + 2 cycles.
- FLUSH: on the edge, clear all valid bits; busywait = 1 for that cycle; next state IDLE.
- flush asserted during MEM_READ:
  - Latched in flush_pending; the fill completes normally.
  - The state then goes to FLUSH instead of IDLE, so the just-filled line is also invalidated.
  - flush_pending clears on entering FLUSH.
- The CPU holds address while busywait is high. The cache does not depend on this, because the miss address is latched.
- Reset (reset == 0 at an edge), including mid-MEM_READ:
  - state = IDLE; all valid = 0; flush_pending = 0; instruction register = 0.
  - The in-flight memory response is discarded.
- While reset is low, outputs are forced to busywait = 0 and mem_read = 0.
- Tag/data storage is not reset; only the valid bits are.
- Any X on mem_readdata outside a completing fill is never captured.

Decomposition:
- cache_pkg holds:
  - state enum {IDLE, MEM_READ, FLUSH};
  - localparams OFFSET_W, INDEX_W, TAG_W, BLOCK_W derived from the parameters;
  - a NOP constant.
- One sub-module, icache_line_array: valid/tag/data storage with one write port, a global valid-clear input, and a combinational read by index.
- The FSM, hit compare and word select live in instruction_cache.

Test Plan:
- Cold miss: after reset, read at 0x0000_0040; memory latency 3 cycles returning words {0x11,0x22,0x33,0x44}.
  - Required: busywait high for 5 cycles; mem_address = 0x0000004 (block address at defaults); instruction = 0x11 on the following hit.
- Same-block hits: reads at 0x44, 0x48, 0x4C on consecutive cycles.
  - Required: busywait = 0 each cycle; instruction = 0x22, 0x33, 0x44; mem_read never asserted.
- Conflict: fill 0x40, then read 0x0000_00C0 (same index 4, different tag).
  - Required: miss and refill; a subsequent read of 0x40 misses again.
- Flush in IDLE: after filling 0x40, pulse flush one cycle.
  - Required: busywait = 1 for one cycle; the next read of 0x40 misses.
- Flush during MEM_READ: pulse flush in the second fill cycle.
  - Required: fill completes, FLUSH follows, and the next read of the same address misses.
- Reset mid-fill: drop reset low during MEM_READ.
  - Required: at the next edge mem_read = 0 and all lines invalid; a late mem_busywait fall is ignored; a read after release misses.
